param_rtc: RTL and testbench
============================

PARAM_RTC -- requirements
Module: param_rtc

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1, the number of clk cycles per one-second tick (legal range 1..65535).
REQ-002 SHALL have parameter DAY_W, default 8, the width of the day counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port run  input  1  count enable; 0 freezes the prescaler and the time.
REQ-006 SHALL have port mode12  input  1  display mode; 1 = 12-hour, 0 = 24-hour.
REQ-007 SHALL have ports set_en  input  1, set_hr  input  5, set_min  input  6, set_sec  input  6  time-load request and value.
REQ-008 SHALL have ports alm_wr  input  1, alm_hr  input  5, alm_min  input  6  alarm-time write request and value.
REQ-009 SHALL have port alm_ack  input  1  clears the alarm flag.
REQ-010 SHALL have ports qsec  output  6, qmin  output  6, qhr  output  5  current time (registered sec/min; display-mapped hour).
REQ-011 SHALL have ports pm  output  1, qday  output  DAY_W, tick  output  1, alarm  output  1, set_err  output  1.

Function
REQ-012 SHALL hold the time internally as 24-hour hr 0..23, min 0..59, sec 0..59.
REQ-013 SHALL count the prescaler 0..CLK_DIV-1 while run=1; tick SHALL be 1 for exactly the cycle in which the prescaler is at CLK_DIV-1 and run=1. With CLK_DIV=1, tick = run.
REQ-014 SHALL advance sec by 1 on the clock edge that ends a tick cycle, so that the new time is visible on the following cycle (one-cycle latency from tick).
REQ-015 SHALL wrap sec 59->0 with a carry to min, min 59->0 with a carry to hr, and hr 23->0 with qday+1; qday SHALL wrap from 2^DAY_W-1 to 0.
REQ-016 SHALL derive qhr combinationally from the internal hour. With mode12=0, qhr = hr. With mode12=1: 0->12, 1..11->unchanged, 12->12, 13..23->hr-12.
REQ-017 SHALL drive pm = 1 when the internal hr >= 12, regardless of mode12.
REQ-018 On set_en=1, SHALL load the set values and clear the prescaler when set_hr<=23, set_min<=59 and set_sec<=59. qday SHALL be unchanged.
REQ-019 On set_en=1 with any out-of-range field, SHALL leave the time unchanged and pulse set_err for one cycle.
REQ-020 set_en SHALL take priority over a tick in the same cycle; that tick's increment SHALL be discarded.
REQ-021 On alm_wr=1 with alm_hr<=23 and alm_min<=59, SHALL store the alarm time and arm the alarm. An invalid alm_wr SHALL leave the stored alarm unchanged and pulse set_err for one cycle.
REQ-022 SHALL set the sticky alarm flag when armed and a tick-driven update produces hr==alm_hr, min==alm_min, sec==0. A set_en load that lands on the alarm time SHALL NOT set the flag.
REQ-023 alarm SHALL stay 1 until alm_ack=1. If alm_ack and a new match occur in the same cycle, alarm SHALL remain 1.
REQ-024 alm_wr SHALL NOT clear an already-set alarm flag.
REQ-025 When set_en and alm_wr are both 1 in the same cycle, SHALL process both independently; set_err SHALL be 1 if either is invalid.
REQ-026 While run=0, tick SHALL be 0 and the prescaler held; set_en, alm_wr and alm_ack SHALL remain functional.

Reset
REQ-027 SHALL, while rst=1 (asynchronously, including mid-count), force: prescaler 0, time 00:00:00, qday 0, tick 0, alarm 0, set_err 0, alarm disarmed, stored alarm 00:00.
REQ-028 SHALL, after reset, show qhr=12 and pm=0 when mode12=1, and qhr=0 when mode12=0.
REQ-029 SHALL begin counting on the first clk edge after rst deasserts, with the first tick CLK_DIV cycles after release when run=1.

Verification
REQ-030 CLK_DIV=4, run=1 from reset: tick every 4th cycle; after 240 ticks qmin=4, qsec=0.
REQ-031 Set 23:59:58 with qday=5, run 2 ticks: time 00:00:00, qday=6, pm 1->0; with DAY_W=3 and qday=7, qday wraps to 0.
REQ-032 Set 13:05:00 with mode12 toggling: qhr=1/pm=1 in 12-hour mode, qhr=13/pm=1 in 24-hour mode; set 00:30:00 gives qhr=12, pm=0 in 12-hour mode.
REQ-033 Set set_hr=24, then set_min=60: each gives a 1-cycle set_err pulse with time unchanged; set_en coincident with tick loads the exact set value.
REQ-034 Alarm 07:00, set 06:59:59, one tick: alarm=1 and held; alm_ack clears it; set 07:00:00 directly: alarm stays 0.
REQ-035 Assert rst mid-count at 10:20:30: outputs go 0 before the next clk edge, with alarm cleared and disarmed.

Source files
------------

// File: rtl/param_rtc.sv
// Real-time clock: prescaled one-second tick, 24h time with 12h display mapping, day counter, one alarm.
// Latency: time, alarm and set_err register one cycle after tick/set_en/alm_wr; tick, qhr and pm are combinational.
// No backpressure: every request is accepted in the cycle it is presented.
module param_rtc #(
    parameter int CLK_DIV = 1,
    parameter int DAY_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             mode12,
    input  logic             set_en,
    input  logic [4:0]       set_hr,
    input  logic [5:0]       set_min,
    input  logic [5:0]       set_sec,
    input  logic             alm_wr,
    input  logic [4:0]       alm_hr,
    input  logic [5:0]       alm_min,
    input  logic             alm_ack,
    output logic [5:0]       qsec,
    output logic [5:0]       qmin,
    output logic [4:0]       qhr,
    output logic             pm,
    output logic [DAY_W-1:0] qday,
    output logic             tick,
    output logic             alarm,
    output logic             set_err
);
    localparam int PW = 16;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] pre;
    logic [4:0]    hr;
    logic [4:0]    alm_hr_q;
    logic [5:0]    alm_min_q;
    logic          armed;

    logic          set_ok;
    logic          alm_ok;
    logic          pre_end;
    logic [5:0]    nsec;
    logic [5:0]    nmin;
    logic [4:0]    nhr;
    logic          day_inc;
    logic          match;

    assign set_ok  = (set_hr <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59);
    assign alm_ok  = (alm_hr <= 5'd23) && (alm_min <= 6'd59);
    assign pre_end = (pre == PRE_MAX);
    // Gated by rst so the CLK_DIV=1 case still reads 0 during reset.
    assign tick    = run & pre_end & ~rst;

    always_comb begin
        nsec    = qsec;
        nmin    = qmin;
        nhr     = hr;
        day_inc = 1'b0;
        if (qsec == 6'd59) begin
            nsec = 6'd0;
            if (qmin == 6'd59) begin
                nmin = 6'd0;
                if (hr == 5'd23) begin
                    nhr     = 5'd0;
                    day_inc = 1'b1;
                end else begin
                    nhr = hr + 5'd1;
                end
            end else begin
                nmin = qmin + 6'd1;
            end
        end else begin
            nsec = qsec + 6'd1;
        end
    end

    // Only a tick that actually advances the time can raise the alarm; any set_en discards it.
    assign match = armed & tick & ~set_en &
                   (nhr == alm_hr_q) & (nmin == alm_min_q) & (nsec == 6'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre       <= '0;
            hr        <= '0;
            qmin      <= '0;
            qsec      <= '0;
            qday      <= '0;
            alm_hr_q  <= '0;
            alm_min_q <= '0;
            armed     <= 1'b0;
            alarm     <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            if (set_en && set_ok) begin
                pre <= '0;
            end else if (run) begin
                pre <= pre_end ? '0 : pre + PW'(1);
            end

            if (set_en) begin
                if (set_ok) begin
                    hr   <= set_hr;
                    qmin <= set_min;
                    qsec <= set_sec;
                end
            end else if (tick) begin
                hr   <= nhr;
                qmin <= nmin;
                qsec <= nsec;
                if (day_inc) begin
                    qday <= qday + DAY_W'(1);
                end
            end

            if (alm_wr && alm_ok) begin
                alm_hr_q  <= alm_hr;
                alm_min_q <= alm_min;
                armed     <= 1'b1;
            end

            if (match) begin
                alarm <= 1'b1;
            end else if (alm_ack) begin
                alarm <= 1'b0;
            end

            set_err <= (set_en & ~set_ok) | (alm_wr & ~alm_ok);
        end
    end

    always_comb begin
        qhr = hr;
        if (mode12) begin
            if (hr == 5'd0) begin
                qhr = 5'd12;
            end else if (hr > 5'd12) begin
                qhr = hr - 5'd12;
            end
        end
    end

    assign pm = (hr >= 5'd12);

endmodule

// File: tb/tb_param_rtc.sv
// Bench for param_rtc built with CLK_DIV=4 and DAY_W=3 so the day wrap is reachable quickly.
module tb_param_rtc;
    localparam int CD = 4;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst, run, mode12;
    logic          set_en, alm_wr, alm_ack;
    logic [4:0]    set_hr, alm_hr;
    logic [5:0]    set_min, set_sec, alm_min;
    logic [5:0]    qsec, qmin;
    logic [4:0]    qhr;
    logic          pm, tick, alarm, set_err;
    logic [DW-1:0] qday;

    param_rtc #(.CLK_DIV(CD), .DAY_W(DW)) dut (
        .clk(clk), .rst(rst), .run(run), .mode12(mode12),
        .set_en(set_en), .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec),
        .alm_wr(alm_wr), .alm_hr(alm_hr), .alm_min(alm_min), .alm_ack(alm_ack),
        .qsec(qsec), .qmin(qmin), .qhr(qhr), .pm(pm), .qday(qday),
        .tick(tick), .alarm(alarm), .set_err(set_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [4:0]    hr;
        logic [5:0]    mn;
        logic [5:0]    sc;
        logic [DW-1:0] day;
        logic          pm;
        logic          alarm;
        logic          err;
    } exp_t;

    typedef struct {
        logic       m12;
        logic [4:0] hr;
        logic [5:0] mn;
        logic [4:0] exp_qhr;
        logic       exp_pm;
    } vec_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic expect_state(input string nm, input logic [4:0] h, input logic [5:0] m,
                                input logic [5:0] s, input logic [DW-1:0] d, input logic p,
                                input logic a, input logic e);
        exp_t x;
        x.name = nm; x.hr = h; x.mn = m; x.sc = s; x.day = d; x.pm = p; x.alarm = a; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: no expected record queued");
            return;
        end
        x = exp_q.pop_front();
        if ({qhr, qmin, qsec, qday, pm, alarm, set_err} !==
            {x.hr, x.mn, x.sc, x.day, x.pm, x.alarm, x.err}) begin
            n_bad++;
            $display("FAIL %s: got %0d:%0d:%0d day=%0d pm=%0d alarm=%0d err=%0d, want %0d:%0d:%0d day=%0d pm=%0d alarm=%0d err=%0d",
                     x.name, qhr, qmin, qsec, qday, pm, alarm, set_err,
                     x.hr, x.mn, x.sc, x.day, x.pm, x.alarm, x.err);
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0b, want %0b", nm, got, want);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_set(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        set_en = 1'b1; set_hr = h; set_min = m; set_sec = s;
        edge1();
        set_en = 1'b0;
    endtask

    task automatic do_alm(input logic [4:0] h, input logic [5:0] m);
        alm_wr = 1'b1; alm_hr = h; alm_min = m;
        edge1();
        alm_wr = 1'b0;
    endtask

    // Prescaler is 0 after every valid set, so CD*n edges process exactly n ticks.
    task automatic run_ticks(input int n);
        run = 1'b1;
        repeat (CD * n) @(posedge clk);
        #1;
        run = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation budget expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{1'b1, 5'd13, 6'd5,  5'd1,  1'b1};
        vecs[1] = '{1'b0, 5'd13, 6'd5,  5'd13, 1'b1};
        vecs[2] = '{1'b1, 5'd0,  6'd30, 5'd12, 1'b0};
        vecs[3] = '{1'b0, 5'd0,  6'd30, 5'd0,  1'b0};
        vecs[4] = '{1'b1, 5'd12, 6'd0,  5'd12, 1'b1};
        vecs[5] = '{1'b1, 5'd11, 6'd59, 5'd11, 1'b0};
        vecs[6] = '{1'b1, 5'd23, 6'd1,  5'd11, 1'b1};
        vecs[7] = '{1'b1, 5'd1,  6'd2,  5'd1,  1'b0};

        rst = 1'b1; run = 1'b1; mode12 = 1'b1;
        set_en = 1'b0; set_hr = '0; set_min = '0; set_sec = '0;
        alm_wr = 1'b0; alm_hr = '0; alm_min = '0; alm_ack = 1'b0;

        // Reset state in both display modes
        #12;
        expect_state("reset_12h", 5'd12, 0, 0, 0, 0, 0, 0);
        check_out();
        check_bit("reset_tick", tick, 1'b0);
        mode12 = 1'b0;
        #1;
        expect_state("reset_24h", 5'd0, 0, 0, 0, 0, 0, 0);
        check_out();

        // Tick cadence from release, then 240 ticks = 4 minutes
        edge1();
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            edge1();
            check_bit($sformatf("tick_edge%0d", i), tick, (i % CD) == (CD - 1));
        end
        expect_state("240_ticks", 0, 4, 0, 0, 0, 0, 0);
        repeat (240 * CD - 8) @(posedge clk);
        #1;
        run = 1'b0;
        check_out();

        // Midnight rollovers and the 3-bit day wrap
        for (int k = 1; k <= 5; k++) begin
            do_set(23, 59, 58);
            run_ticks(2);
        end
        expect_state("day5", 0, 0, 0, 5, 0, 0, 0);
        check_out();
        do_set(23, 59, 58);
        run_ticks(1);
        expect_state("pre_midnight", 23, 59, 59, 5, 1, 0, 0);
        check_out();
        run_ticks(1);
        expect_state("midnight_day6", 0, 0, 0, 6, 0, 0, 0);
        check_out();
        do_set(23, 59, 58);
        run_ticks(2);
        do_set(23, 59, 58);
        run_ticks(2);
        expect_state("day_wrap", 0, 0, 0, 0, 0, 0, 0);
        check_out();

        // Display mapping table
        foreach (vecs[i]) begin
            mode12 = vecs[i].m12;
            do_set(vecs[i].hr, vecs[i].mn, 0);
            expect_state($sformatf("mode_vec%0d", i), vecs[i].exp_qhr, vecs[i].mn, 0, 0,
                         vecs[i].exp_pm, 0, 0);
            check_out();
        end
        mode12 = 1'b0;

        // Range errors: time unchanged, one-cycle set_err
        do_set(10, 0, 0);
        do_set(24, 0, 0);
        expect_state("bad_hr", 10, 0, 0, 0, 0, 0, 1);
        check_out();
        edge1();
        expect_state("bad_hr_clear", 10, 0, 0, 0, 0, 0, 0);
        check_out();
        do_set(10, 60, 0);
        expect_state("bad_min", 10, 0, 0, 0, 0, 0, 1);
        check_out();
        edge1();
        check_bit("bad_min_clear", set_err, 1'b0);
        do_alm(7, 60);
        check_bit("bad_alm_min", set_err, 1'b1);
        set_en = 1'b1; set_hr = 3; set_min = 4; set_sec = 5;
        alm_wr = 1'b1; alm_hr = 24; alm_min = 0;
        edge1();
        set_en = 1'b0; alm_wr = 1'b0;
        expect_state("set_ok_alm_bad", 3, 4, 5, 0, 0, 0, 1);
        check_out();

        // set_en on the tick cycle loads the exact value
        do_set(10, 0, 0);
        run = 1'b1;
        repeat (CD - 1) edge1();
        check_bit("tick_before_set", tick, 1'b1);
        set_en = 1'b1; set_hr = 5; set_min = 6; set_sec = 7;
        edge1();
        set_en = 1'b0; run = 1'b0;
        expect_state("set_over_tick", 5, 6, 7, 0, 0, 0, 0);
        check_out();

        // Alarm: tick match, hold, ack, direct-set no-match
        do_alm(7, 0);
        do_set(6, 59, 59);
        run_ticks(1);
        expect_state("alarm_hit", 7, 0, 0, 0, 0, 1, 0);
        check_out();
        repeat (3) edge1();
        check_bit("alarm_held", alarm, 1'b1);
        alm_ack = 1'b1;
        edge1();
        alm_ack = 1'b0;
        check_bit("alarm_acked", alarm, 1'b0);
        do_set(7, 0, 0);
        edge1();
        check_bit("alarm_direct_set", alarm, 1'b0);
        do_set(6, 59, 59);
        run = 1'b1;
        repeat (CD - 1) edge1();
        alm_ack = 1'b1;
        edge1();
        alm_ack = 1'b0; run = 1'b0;
        check_bit("alarm_ack_and_match", alarm, 1'b1);
        do_alm(8, 0);
        check_bit("alm_wr_keeps_flag", alarm, 1'b1);

        // Asynchronous reset mid-count, then confirm the alarm is disarmed
        do_alm(7, 0);
        do_set(10, 20, 30);
        run = 1'b1;
        edge1();
        edge1();
        #2;
        rst = 1'b1;
        #1;
        expect_state("async_reset", 0, 0, 0, 0, 0, 0, 0);
        check_out();
        check_bit("async_reset_tick", tick, 1'b0);
        run = 1'b0;
        edge1();
        rst = 1'b0;
        do_set(23, 59, 59);
        run_ticks(1);
        expect_state("disarmed_after_reset", 0, 0, 0, 1, 0, 0, 0);
        check_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
